// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: phase and rw encodings, request
// FSM state type, and the default protected-region base.
package bus_responder_pkg;

  typedef enum logic {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } phase_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } req_state_e;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'hE000;

  function automatic logic in_rom(input logic [15:0] addr, input logic [15:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/bus_phase_tracker.sv
// Tracks the LO/HI phase of the CPU's two-clock multiplexed bus cycle.
// resync pulls the next phase back to LO; txn_done flags the HI cycle whose
// closing edge completes a transaction.
module bus_phase_tracker
  import bus_responder_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   resync,
  output phase_e phase,
  output logic   txn_done
);

  // Phase toggle register; resync forces the following cycle to LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PHASE_LO;
    end else if (resync) begin
      phase <= PHASE_LO;
    end else if (phase == PHASE_LO) begin
      phase <= PHASE_HI;
    end else begin
      phase <= PHASE_LO;
    end
  end

  // A resync during HI abandons the transaction being assembled.
  assign txn_done = (phase == PHASE_HI) && !resync;

endmodule

// File: rtl/bus_responder.sv
// Memory-side end of the CPU's time-multiplexed external bus. Demultiplexes
// LO (addr low + rw) and HI (addr high + wdata) phases into a 16-bit
// req/ack memory request and returns read data on bus_data_out.
// Optional feature: define BUS_RESPONDER_ROM_PROTECT_EN to drop writes at or
// above ROM_BASE and flag them on wr_fault.
//
// Request FSM
//   state    | meaning
//   REQ_IDLE | no outstanding memory request
//   REQ_PEND | mem_req high, addr/we/wdata held until mem_ack
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEFAULT,
  parameter int          RW_BIT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bus_addr_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic        resync,
  output logic        phase_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        overrun,
  output logic        wr_fault
);

`ifdef BUS_RESPONDER_ROM_PROTECT_EN
  localparam logic PROTECT_EN = 1'b1;
`else
  localparam logic PROTECT_EN = 1'b0;
`endif

  phase_e     phase;
  logic       txn_done;
  logic [7:0] addr_lo;
  logic       rw_lat;
  req_state_e state;

  logic [15:0] new_addr;
  logic        new_we;
  logic        blocked;

  bus_phase_tracker u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .resync   (resync),
    .phase    (phase),
    .txn_done (txn_done)
  );

  assign phase_out = phase;

  // Capture the LO-phase half of the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo <= 8'h00;
      rw_lat  <= 1'b0;
    end else if (phase == PHASE_LO) begin
      addr_lo <= bus_addr_in;
      rw_lat  <= bus_data_in[RW_BIT];
    end
  end

  // HI-phase inputs are consumed directly on the completing edge.
  assign new_addr = {bus_addr_in, addr_lo};
  assign new_we   = (rw_lat == RW_WRITE);
  assign blocked  = PROTECT_EN && new_we && in_rom(new_addr, ROM_BASE);

  // Request FSM: retire on ack first, then let a completing transaction
  // load over it so ack and a new request can share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= REQ_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 16'h0000;
      mem_wdata    <= 8'h00;
      bus_data_out <= 8'h00;
      overrun      <= 1'b0;
      wr_fault     <= 1'b0;
    end else begin
      if (state == REQ_PEND && mem_ack) begin
        state   <= REQ_IDLE;
        mem_req <= 1'b0;
        if (!mem_we) begin
          bus_data_out <= mem_rdata;
        end
      end
      if (txn_done) begin
        if (blocked) begin
          wr_fault <= 1'b1;
        end else begin
          if (state == REQ_PEND && !mem_ack) begin
            overrun <= 1'b1;
          end
          state    <= REQ_PEND;
          mem_req  <= 1'b1;
          mem_addr <= new_addr;
          mem_we   <= new_we;
          if (new_we) begin
            mem_wdata <= bus_data_in;
          end
        end
      end
    end
  end

endmodule
